// File: rtl/dnp3_link_tx_arbiter_if.sv
// Request/transmit bundle shared by the DNP3 responders, the link TX arbiter
// and the byte transmitter. The master side drives requests and tx_ready;
// the slave side (the arbiter) answers with grant/done and the byte stream.
interface dnp3_link_tx_arbiter_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]    req;
    logic [8*NUM_REQ-1:0]  req_ctrl;
    logic [16*NUM_REQ-1:0] req_dest;
    logic [NUM_REQ-1:0]    grant;
    logic                  done;
    logic [7:0]            tx_data;
    logic                  tx_valid;
    logic                  tx_ready;

    modport master (
        output req, req_ctrl, req_dest, tx_ready,
        input  grant, done, tx_data, tx_valid
    );

    modport slave (
        input  req, req_ctrl, req_dest, tx_ready,
        output grant, done, tx_data, tx_valid
    );
endinterface

// File: rtl/dnp3_link_tx_arbiter.sv
// Round-robin arbiter and sequencer for the shared DNP3 link-layer header
// transmit path. Each granted requester gets one header-only frame
// 05 64 LEN CTRL DEST_L DEST_H SRC_L SRC_H CRC_L CRC_H on a valid/ready stream.
// Optional feature macro: DNP3_TX_FCB_EN (per-requester frame count bit
// substituted into CTRL bit5 when CTRL bit4 (FCV) is set).

// DNP3 CRC-16 (poly 0x3D65 reflected, output complemented). Clearing presets
// the state with the constant 05 64 start octets already absorbed, so the
// arbiter only has to feed the six variable header bytes.
module crc16_dnp (
    input  logic        clk,
    input  logic        rst,
    input  logic        crcClear_i,
    input  logic        dataValid_i,
    input  logic [7:0]  data_i,
    output logic [15:0] crcOut_o
);
    function automatic logic [15:0] crcByte(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c ^ {8'h00, b};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 16'hA6BC) : (r >> 1);
        end
        return r;
    endfunction

    localparam logic [15:0] SEED = crcByte(crcByte(16'h0000, 8'h05), 8'h64);

    logic [15:0] crc_q;

    // CRC state: preset on clear, absorb one byte per valid cycle
    always_ff @(posedge clk) begin
        if (rst || crcClear_i) begin
            crc_q <= SEED;
        end else if (dataValid_i) begin
            crc_q <= crcByte(crc_q, data_i);
        end
    end

    assign crcOut_o = ~crc_q;
endmodule

module dnp3_link_tx_arbiter #(
    parameter int          NUM_REQ    = 2,
    parameter logic [15:0] MY_ADDRESS = 16'h0001,
    parameter logic [7:0]  LENGTH     = 8'h05
) (
    input logic                   clk,
    input logic                   rst,
    dnp3_link_tx_arbiter_if.slave link_bus
);
    localparam int IW = (NUM_REQ > 2) ? 2 : 1;

    typedef enum logic [1:0] {IDLE, CALC, SETTLE, SEND} state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IW-1:0]      last_q, last_d;
    logic [IW-1:0]      sel_q, sel_d;
    logic [7:0]         ctrl_q, ctrl_d;
    logic [15:0]        dest_q, dest_d;
    logic [2:0]         calcIdx_q, calcIdx_d;
    logic [3:0]         txIdx_q, txIdx_d;
    logic [15:0]        crcLat_q, crcLat_d;
    logic               done_q, done_d;
`ifdef DNP3_TX_FCB_EN
    logic [NUM_REQ-1:0] fcb_q, fcb_d;
`endif

    logic [IW-1:0] pick;
    logic          pickFound;
    int            rrCand;
    logic [7:0]    ctrlEff;
    logic          crcClear;
    logic          crcValid;
    logic [7:0]    crcData;
    logic [15:0]   crcOut;
    logic          handshake;

    crc16_dnp u_crc (
        .clk        (clk),
        .rst        (rst),
        .crcClear_i (crcClear),
        .dataValid_i(crcValid),
        .data_i     (crcData),
        .crcOut_o   (crcOut)
    );

    // Round-robin search: first requesting index after the last one served
    always_comb begin
        pick      = '0;
        pickFound = 1'b0;
        rrCand    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            rrCand = int'(last_q) + 1 + k;
            if (rrCand >= NUM_REQ) begin
                rrCand = rrCand - NUM_REQ;
            end
            if (!pickFound && link_bus.req[rrCand[IW-1:0]]) begin
                pick      = rrCand[IW-1:0];
                pickFound = 1'b1;
            end
        end
    end

    // Control byte actually sent, with the FCB substituted when enabled and FCV is set
    always_comb begin
`ifdef DNP3_TX_FCB_EN
        ctrlEff = ctrl_q[4] ? {ctrl_q[7:6], fcb_q[sel_q], ctrl_q[4:0]} : ctrl_q;
`else
        ctrlEff = ctrl_q;
`endif
    end

    // State register: all sequential state, synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            last_q    <= IW'(NUM_REQ - 1);
            sel_q     <= '0;
            ctrl_q    <= '0;
            dest_q    <= '0;
            calcIdx_q <= '0;
            txIdx_q   <= '0;
            crcLat_q  <= '0;
            done_q    <= 1'b0;
`ifdef DNP3_TX_FCB_EN
            fcb_q     <= '1;
`endif
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            sel_q     <= sel_d;
            ctrl_q    <= ctrl_d;
            dest_q    <= dest_d;
            calcIdx_q <= calcIdx_d;
            txIdx_q   <= txIdx_d;
            crcLat_q  <= crcLat_d;
            done_q    <= done_d;
`ifdef DNP3_TX_FCB_EN
            fcb_q     <= fcb_d;
`endif
        end
    end

    // Next-state: select and latch a requester, run the CRC, then stream the frame
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        sel_d     = sel_q;
        ctrl_d    = ctrl_q;
        dest_d    = dest_q;
        calcIdx_d = calcIdx_q;
        txIdx_d   = txIdx_q;
        crcLat_d  = crcLat_q;
        done_d    = 1'b0;
`ifdef DNP3_TX_FCB_EN
        fcb_d     = fcb_q;
`endif
        case (state_q)
            IDLE: begin
                if (pickFound) begin
                    state_d       = CALC;
                    sel_d         = pick;
                    grant_d       = '0;
                    grant_d[pick] = 1'b1;
                    ctrl_d        = link_bus.req_ctrl[8*int'(pick) +: 8];
                    dest_d        = link_bus.req_dest[16*int'(pick) +: 16];
                    calcIdx_d     = '0;
                end
            end
            CALC: begin
                calcIdx_d = calcIdx_q + 3'd1;
                if (calcIdx_q == 3'd5) begin
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                crcLat_d = crcOut;
                txIdx_d  = '0;
                state_d  = SEND;
            end
            SEND: begin
                if (handshake) begin
                    if (txIdx_q == 4'd9) begin
                        state_d = IDLE;
                        grant_d = '0;
                        done_d  = 1'b1;
                        last_d  = sel_q;
`ifdef DNP3_TX_FCB_EN
                        if (ctrl_q[4]) begin
                            fcb_d[sel_q] = ~fcb_q[sel_q];
                        end
`endif
                    end else begin
                        txIdx_d = txIdx_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: CRC feed during CALC, frame byte mux during SEND, registered grant/done
    always_comb begin
        handshake = (state_q == SEND) && link_bus.tx_ready;
        crcClear  = (state_q == IDLE) && pickFound;
        crcValid  = (state_q == CALC);
        case (calcIdx_q)
            3'd0:    crcData = LENGTH;
            3'd1:    crcData = ctrlEff;
            3'd2:    crcData = dest_q[7:0];
            3'd3:    crcData = dest_q[15:8];
            3'd4:    crcData = MY_ADDRESS[7:0];
            3'd5:    crcData = MY_ADDRESS[15:8];
            default: crcData = 8'h00;
        endcase
        link_bus.tx_valid = (state_q == SEND);
        link_bus.tx_data  = 8'h00;
        if (state_q == SEND) begin
            case (txIdx_q)
                4'd0:    link_bus.tx_data = 8'h05;
                4'd1:    link_bus.tx_data = 8'h64;
                4'd2:    link_bus.tx_data = LENGTH;
                4'd3:    link_bus.tx_data = ctrlEff;
                4'd4:    link_bus.tx_data = dest_q[7:0];
                4'd5:    link_bus.tx_data = dest_q[15:8];
                4'd6:    link_bus.tx_data = MY_ADDRESS[7:0];
                4'd7:    link_bus.tx_data = MY_ADDRESS[15:8];
                4'd8:    link_bus.tx_data = crcLat_q[7:0];
                4'd9:    link_bus.tx_data = crcLat_q[15:8];
                default: link_bus.tx_data = 8'h00;
            endcase
        end
        link_bus.grant = grant_q;
        link_bus.done  = done_q;
    end
endmodule

// File: tb/tb_dnp3_link_tx_arbiter.sv
// Bench for dnp3_link_tx_arbiter: stimulus pushes expected frame bytes into a
// scoreboard, an independent negedge monitor pops and compares on every accepted byte.
module tb_dnp3_link_tx_arbiter;
    localparam int          NR     = 4;
    localparam logic [15:0] MYADDR = 16'h0400;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   hsCount = 0;
    int   doneCount = 0;
    int   expDone = 0;
    int   lastHsCyc = 0;
    int   bytesInFrame = 0;
    bit   stallMode = 1'b0;
    logic readyForce = 1'b1;
    bit   prevStall = 1'b0;
    bit   prevRst = 1'b1;
    logic [7:0] prevData = 8'h00;
    logic [7:0] expByteQ [$];
    logic [3:0] expGrantQ [$];
    logic [7:0] wireA, wireB;

    dnp3_link_tx_arbiter_if #(.NUM_REQ(NR)) bus ();

    dnp3_link_tx_arbiter #(
        .NUM_REQ   (NR),
        .MY_ADDRESS(MYADDR),
        .LENGTH    (8'h05)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .link_bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Sink readiness: either forced level or ~50% random stalls
    always @(posedge clk) begin
        #2;
        if (stallMode) bus.tx_ready = 1'($urandom_range(0, 1));
        else           bus.tx_ready = readyForce;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Expected frame built from bench values with an independent CRC model
    task automatic pushFrame(input int r, input logic [7:0] wireCtrl, input logic [15:0] dest, input int nBytes);
        logic [7:0]  b [10];
        logic [15:0] c;
        b[0] = 8'h05; b[1] = 8'h64; b[2] = 8'h05; b[3] = wireCtrl;
        b[4] = dest[7:0]; b[5] = dest[15:8]; b[6] = MYADDR[7:0]; b[7] = MYADDR[15:8];
        c = 16'h0000;
        for (int i = 0; i < 8; i++) begin
            c = c ^ {8'h00, b[i]};
            for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 16'hA6BC) : (c >> 1);
        end
        c = ~c;
        b[8] = c[7:0]; b[9] = c[15:8];
        for (int i = 0; i < nBytes; i++) begin
            expByteQ.push_back(b[i]);
            expGrantQ.push_back(4'(1 << r));
        end
        if (nBytes == 10) expDone++;
    endtask

    // Hand-computed reference frame for requester 0, ctrl C0, dest 0001
    task automatic pushLiteral();
        logic [7:0] lit [10];
        lit = '{8'h05, 8'h64, 8'h05, 8'hC0, 8'h01, 8'h00, 8'h00, 8'h04, 8'hE9, 8'h21};
        for (int i = 0; i < 10; i++) begin
            expByteQ.push_back(lit[i]);
            expGrantQ.push_back(4'b0001);
        end
        expDone++;
    endtask

    task automatic applyStimulus(input int r, input logic [7:0] ctrl, input logic [15:0] dest);
        bus.req_ctrl[8*r +: 8]   = ctrl;
        bus.req_dest[16*r +: 16] = dest;
        bus.req[r]               = 1'b1;
    endtask

    task automatic waitGrant(input int r);
        bit got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(posedge clk); #1;
            if (bus.grant[r]) got = 1'b1;
        end
        checkOutput("grant seen", 32'(got), 32'd1);
        checkOutput("grant onehot", 32'(bus.grant), 32'(1 << r));
    endtask

    task automatic waitDone(input int target);
        bit got = 1'b0;
        for (int i = 0; i < 600 && !got; i++) begin
            @(posedge clk); #1;
            if (doneCount >= target) got = 1'b1;
        end
        checkOutput("done seen", 32'(got), 32'd1);
    endtask

    // One request: raise, drop right after grant, scramble inputs, wait for done
    task automatic runReq(input int r, input logic [7:0] ctrl, input logic [15:0] dest);
        int target;
        target = doneCount + 1;
        @(posedge clk); #1;
        applyStimulus(r, ctrl, dest);
        waitGrant(r);
        bus.req[r]               = 1'b0;
        bus.req_ctrl[8*r +: 8]   = ~ctrl;
        bus.req_dest[16*r +: 16] = ~dest;
        waitDone(target);
    endtask

    task automatic doReset();
        @(posedge clk); #1;
        rst     = 1'b1;
        bus.req = '0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Scoreboard monitor: byte/grant compare on handshake, done framing, stall stability
    always @(negedge clk) begin
        if (prevStall && !prevRst) begin
            checkOutput("stall valid", 32'(bus.tx_valid), 32'd1);
            checkOutput("stall data", 32'(bus.tx_data), 32'(prevData));
        end
        prevStall = bus.tx_valid && !bus.tx_ready;
        prevData  = bus.tx_data;
        prevRst   = rst;
        if (rst) begin
            bytesInFrame = 0;
        end else begin
            if (bus.tx_valid && bus.tx_ready) begin
                if (expByteQ.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL extra byte: got %0h expected none", bus.tx_data);
                end else begin
                    checkOutput("tx byte", 32'(bus.tx_data), 32'(expByteQ.pop_front()));
                    checkOutput("byte grant", 32'(bus.grant), 32'(expGrantQ.pop_front()));
                end
                hsCount++;
                lastHsCyc = cyc;
                bytesInFrame++;
            end
            if (bus.done) begin
                doneCount++;
                checkOutput("done gap", 32'(cyc - lastHsCyc), 32'd1);
                checkOutput("frame len", 32'(bytesInFrame), 32'd10);
                checkOutput("grant at done", 32'(bus.grant), 32'd0);
                bytesInFrame = 0;
            end
        end
    end

    initial begin
        int base;
        int target;
        rst          = 1'b1;
        bus.req      = '0;
        bus.req_ctrl = '0;
        bus.req_dest = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset grant", 32'(bus.grant), 32'd0);
        checkOutput("reset done", 32'(bus.done), 32'd0);
        checkOutput("reset valid", 32'(bus.tx_valid), 32'd0);
        checkOutput("reset data", 32'(bus.tx_data), 32'd0);
        rst = 1'b0;

        $display("[TB] reference frame and latency");
        pushLiteral();
        target = doneCount + 1;
        @(posedge clk); #1;
        applyStimulus(0, 8'hC0, 16'h0001);
        for (int i = 1; i <= 7; i++) begin
            @(posedge clk); #1;
            if (i == 1) bus.req[0] = 1'b0;
        end
        checkOutput("valid at N+7", 32'(bus.tx_valid), 32'd0);
        @(posedge clk); #1;
        checkOutput("valid at N+8", 32'(bus.tx_valid), 32'd1);
        checkOutput("first byte", 32'(bus.tx_data), 32'h05);
        waitDone(target);

        $display("[TB] request dropped during CALC");
        pushFrame(2, 8'h44, 16'h0A0B, 10);
        runReq(2, 8'h44, 16'h0A0B);

        $display("[TB] random sink stalls");
        stallMode = 1'b1;
        pushLiteral();
        runReq(0, 8'hC0, 16'h0001);
        stallMode = 1'b0;

        $display("[TB] four requesters continuously");
        doReset();
        pushFrame(0, 8'hC0, 16'h1000, 10);
        pushFrame(1, 8'h44, 16'h1101, 10);
        pushFrame(2, 8'h0B, 16'h1202, 10);
        pushFrame(3, 8'h09, 16'h1303, 10);
        pushFrame(0, 8'hC0, 16'h1000, 10);
        target = doneCount + 4;
        @(posedge clk); #1;
        applyStimulus(0, 8'hC0, 16'h1000);
        applyStimulus(1, 8'h44, 16'h1101);
        applyStimulus(2, 8'h0B, 16'h1202);
        applyStimulus(3, 8'h09, 16'h1303);
        waitDone(target);
        bus.req = '0;
        checkOutput("fifth grant", 32'(bus.grant), 32'd1);
        waitDone(target + 1);

        $display("[TB] reset during SEND");
        pushFrame(1, 8'h44, 16'h2222, 4);
        base = hsCount;
        @(posedge clk); #1;
        applyStimulus(1, 8'h44, 16'h2222);
        waitGrant(1);
        applyStimulus(0, 8'hC4, 16'h0077);
        begin
            bit got = 1'b0;
            for (int i = 0; i < 100 && !got; i++) begin
                @(posedge clk); #1;
                if (hsCount >= base + 4) got = 1'b1;
            end
            checkOutput("reach index 4", 32'(got), 32'd1);
        end
        rst        = 1'b1;
        readyForce = 1'b0;
        pushFrame(0, 8'hC4, 16'h0077, 10);
        @(posedge clk); #1;
        checkOutput("rst valid", 32'(bus.tx_valid), 32'd0);
        checkOutput("rst grant", 32'(bus.grant), 32'd0);
        rst        = 1'b0;
        readyForce = 1'b1;
        target     = doneCount + 1;
        waitGrant(0);
        bus.req = '0;
        waitDone(target);

        $display("[TB] FCB handling");
        doReset();
`ifdef DNP3_TX_FCB_EN
        wireA = 8'h73;
        wireB = 8'h53;
`else
        wireA = 8'h53;
        wireB = 8'h53;
`endif
        pushFrame(1, wireA, 16'h0203, 10);
        runReq(1, 8'h53, 16'h0203);
        pushFrame(1, wireB, 16'h0203, 10);
        runReq(1, 8'h53, 16'h0203);

        repeat (5) @(posedge clk);
        #1;
        checkOutput("queue empty", 32'(expByteQ.size()), 32'd0);
        checkOutput("done count", 32'(doneCount), 32'(expDone));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
